// File: rtl/mode4_tree_feeder.sv
// -----------------------------------------------------------------------------
// mode4_tree_feeder
//
// Upstream sequencer for the mode-4 four-input adder tree in the attention
// layer. A start request streams one Q/K/V vector out of the buffer RAM in
// four-element beats, presents each beat on the tree operands, drives the
// tree stage enables as a pipelined valid chain, clears the tree accumulator
// once per vector and finally hands the accumulated sum downstream through a
// valid/ready handshake. No arithmetic is done here; the tree owns the sum.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   start, start_ready  vector request / block idle and able to accept it
//   base_addr           first buffer word, sampled when start is accepted
//   rd_en, rd_addr      buffer read strobe and address
//   rd_data             buffer word, valid the cycle after rd_en
//   inp0..inp3          tree operands (lane N = rd_data[N*DATA_WIDTH +: DATA_WIDTH])
//   stage2/1/0_run      tree stage enables
//   tree_clr            synchronous clear to the tree (also high during reset)
//   tree_outp           tree accumulator output
//   result              captured vector sum
//   result_valid        result holds a valid sum
//   result_ready        downstream accepts result
//   busy                sequencer not idle
// -----------------------------------------------------------------------------
module mode4_tree_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int NUM_BEATS  = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        start_ready,
  input  logic [ADDR_W-1:0]           base_addr,
  output logic                        rd_en,
  output logic [ADDR_W-1:0]           rd_addr,
  input  logic [LANES*DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0]       inp0,
  output logic [DATA_WIDTH-1:0]       inp1,
  output logic [DATA_WIDTH-1:0]       inp2,
  output logic [DATA_WIDTH-1:0]       inp3,
  output logic                        stage2_run,
  output logic                        stage1_run,
  output logic                        stage0_run,
  output logic                        tree_clr,
  input  logic [DATA_WIDTH-1:0]       tree_outp,
  output logic [DATA_WIDTH-1:0]       result,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic                        busy
);

  // Beat counter only needs to reach NUM_BEATS-1.
  localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    DRAIN,
    HOLD
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [CNT_W-1:0]        k_q, k_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    v0_q, s2_q, s1_q, s0_q;
  logic [DATA_WIDTH-1:0]   inp0_q, inp1_q, inp2_q, inp3_q;
  logic                    pipe_empty;

  // Control state: FSM state, latched base address, beat counter and the
  // captured sum.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      k_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      k_q      <= k_d;
      result_q <= result_d;
    end
  end

  // Valid chain and operand registers. The read data arrives one cycle after
  // rd_en (v0), is registered into the operands, and the stage enables then
  // trail that beat through the tree one stage per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v0_q   <= 1'b0;
      s2_q   <= 1'b0;
      s1_q   <= 1'b0;
      s0_q   <= 1'b0;
      inp0_q <= '0;
      inp1_q <= '0;
      inp2_q <= '0;
      inp3_q <= '0;
    end else begin
      v0_q <= rd_en;
      s2_q <= v0_q;
      s1_q <= s2_q;
      s0_q <= s1_q;
      if (v0_q) begin
        inp0_q <= rd_data[0*DATA_WIDTH +: DATA_WIDTH];
        inp1_q <= rd_data[1*DATA_WIDTH +: DATA_WIDTH];
        inp2_q <= rd_data[2*DATA_WIDTH +: DATA_WIDTH];
        inp3_q <= rd_data[3*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The first cycle with the whole chain quiet is the cycle after the last
  // stage0 enable, which is exactly when the accumulator holds the final sum.
  assign pipe_empty = !(v0_q || s2_q || s1_q || s0_q);

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    k_d      = k_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          k_d     = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (k_q == LAST_BEAT) begin
          state_d = DRAIN;
        end else begin
          k_d = k_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          result_d = tree_outp;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign start_ready  = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign rd_en        = (state_q == FETCH);
  assign rd_addr      = (state_q == FETCH) ? (base_q + ADDR_W'(k_q)) : '0;
  // Reset reaches the tree combinationally so it is cleared in the same cycles.
  assign tree_clr     = !reset || (state_q == CLEAR);
  assign result_valid = (state_q == HOLD);
  assign result       = result_q;
  assign inp0         = inp0_q;
  assign inp1         = inp1_q;
  assign inp2         = inp2_q;
  assign inp3         = inp3_q;
  assign stage2_run   = s2_q;
  assign stage1_run   = s1_q;
  assign stage0_run   = s0_q;

endmodule

// File: tb/tb_mode4_tree_feeder.sv
// -----------------------------------------------------------------------------
// tb_mode4_tree_feeder
//
// Self-checking bench for mode4_tree_feeder. It provides a registered-read
// buffer RAM and a small behavioural model of the mode-4 adder tree
// (pairwise adds, then a pair add, then a saturating accumulator), drives
// directed vectors and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_mode4_tree_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        start_ready;
  logic [3:0]  base_addr;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [63:0] rd_data;
  logic [15:0] inp0, inp1, inp2, inp3;
  logic        stage2_run, stage1_run, stage0_run;
  logic        tree_clr;
  logic [15:0] tree_outp;
  logic [15:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        busy;

  int checks = 0;
  int passes = 0;

  // Observations gathered by run_vector.
  int          s2First, s2Last, s2Cnt;
  int          s1First, s1Last, s1Cnt;
  int          s0First, s0Last, s0Cnt;
  int          clrFirst, clrCnt;
  int          rvCyc;
  logic [3:0]  addrQ[$];

  logic [63:0] mem [16];

  mode4_tree_feeder dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .start_ready  (start_ready),
    .base_addr    (base_addr),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .inp0         (inp0),
    .inp1         (inp1),
    .inp2         (inp2),
    .inp3         (inp3),
    .stage2_run   (stage2_run),
    .stage1_run   (stage1_run),
    .stage0_run   (stage0_run),
    .tree_clr     (tree_clr),
    .tree_outp    (tree_outp),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Buffer RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Behavioural adder tree: saturate to 0x7000 on carry-out.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'h7000 : s[15:0];
  endfunction

  logic [15:0] s2a, s2b, s1v, acc;
  always @(posedge clk) begin
    if (tree_clr) begin
      s2a <= '0; s2b <= '0; s1v <= '0; acc <= '0;
    end else begin
      if (stage2_run) begin
        s2a <= sat_add(inp0, inp1);
        s2b <= sat_add(inp2, inp3);
      end
      if (stage1_run) s1v <= sat_add(s2a, s2b);
      if (stage0_run) acc <= sat_add(acc, s1v);
    end
  end
  assign tree_outp = acc;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic fill_const(input logic [15:0] v);
    for (int w = 0; w < 16; w++) mem[w] = {4{v}};
  endtask

  task automatic fill_addr();
    for (int w = 0; w < 16; w++) mem[w] = {4{16'(w)}};
  endtask

  // Starts one vector (start sampled in cycle 0) and records per-cycle
  // observations until result_valid is seen or the budget runs out. Returns
  // at the negedge of the first result_valid cycle, leaving the DUT in HOLD.
  task automatic run_vector(input logic [3:0] base);
    s2First = -1; s2Last = -1; s2Cnt = 0;
    s1First = -1; s1Last = -1; s1Cnt = 0;
    s0First = -1; s0Last = -1; s0Cnt = 0;
    clrFirst = -1; clrCnt = 0; rvCyc = -1;
    addrQ.delete();
    result_ready = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    @(posedge clk);
    for (int c = 1; c <= 60 && rvCyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (stage2_run) begin if (s2First < 0) s2First = c; s2Last = c; s2Cnt++; end
      if (stage1_run) begin if (s1First < 0) s1First = c; s1Last = c; s1Cnt++; end
      if (stage0_run) begin if (s0First < 0) s0First = c; s0Last = c; s0Cnt++; end
      if (tree_clr) begin if (clrFirst < 0) clrFirst = c; clrCnt++; end
      if (rd_en) addrQ.push_back(rd_addr);
      if (result_valid) rvCyc = c;
    end
  endtask

  task automatic release_result();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; base_addr = '0; result_ready = 1'b0;
    fill_const(16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rd_en, rd_addr, stage2_run, stage1_run, stage0_run, result_valid, busy} !== 10'b0)
      $display("[TB] FAIL reset_ctrl: got %b expected 0", {rd_en, rd_addr, stage2_run, stage1_run, stage0_run, result_valid, busy});
    else passes++;
    checks++;
    if ({inp0, inp1, inp2, inp3, result} !== 80'b0)
      $display("[TB] FAIL reset_data: got %h expected 0", {inp0, inp1, inp2, inp3, result});
    else passes++;
    checks++;
    if (tree_clr !== 1'b1) $display("[TB] FAIL reset_tree_clr: got %b expected 1", tree_clr);
    else passes++;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || tree_clr !== 1'b0)
      $display("[TB] FAIL idle_after_reset: got ready=%b clr=%b expected ready=1 clr=0", start_ready, tree_clr);
    else passes++;
  endtask

  task automatic test_basic();
    int bad;
    fill_const(16'h0001);
    run_vector(4'd0);
    checks++;
    if (rvCyc !== 23) $display("[TB] FAIL basic_valid_cycle: got %0d expected 23", rvCyc);
    else passes++;
    checks++;
    if (result !== 16'h0040) $display("[TB] FAIL basic_result: got %h expected 0040", result);
    else passes++;
    checks++;
    if (clrFirst !== 1 || clrCnt !== 1)
      $display("[TB] FAIL basic_clear: got first=%0d count=%0d expected first=1 count=1", clrFirst, clrCnt);
    else passes++;
    checks++;
    if (s2First !== 4 || s2Last !== 19 || s2Cnt !== 16)
      $display("[TB] FAIL basic_stage2: got %0d..%0d n=%0d expected 4..19 n=16", s2First, s2Last, s2Cnt);
    else passes++;
    checks++;
    if (s1First !== 5 || s1Last !== 20 || s1Cnt !== 16)
      $display("[TB] FAIL basic_stage1: got %0d..%0d n=%0d expected 5..20 n=16", s1First, s1Last, s1Cnt);
    else passes++;
    checks++;
    if (s0First !== 6 || s0Last !== 21 || s0Cnt !== 16)
      $display("[TB] FAIL basic_stage0: got %0d..%0d n=%0d expected 6..21 n=16", s0First, s0Last, s0Cnt);
    else passes++;
    bad = 0;
    for (int i = 0; i < addrQ.size(); i++) if (addrQ[i] !== 4'(i)) bad++;
    checks++;
    if (addrQ.size() != 16 || bad != 0)
      $display("[TB] FAIL basic_addr_seq: got %0d reads %0d wrong expected 16 reads 0..15", addrQ.size(), bad);
    else passes++;
    release_result();
  endtask

  task automatic test_wrap();
    int bad;
    fill_addr();
    run_vector(4'd12);
    bad = 0;
    for (int i = 0; i < addrQ.size(); i++) if (addrQ[i] !== 4'(12 + i)) bad++;
    checks++;
    if (addrQ.size() != 16 || bad != 0)
      $display("[TB] FAIL wrap_addr_seq: got %0d reads %0d wrong expected 16 reads 12..15,0..11", addrQ.size(), bad);
    else passes++;
    checks++;
    if (result !== 16'h01E0) $display("[TB] FAIL wrap_result: got %h expected 01e0", result);
    else passes++;
    release_result();
  endtask

  task automatic test_hold();
    int bad;
    fill_const(16'h0001);
    run_vector(4'd0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      @(negedge clk);
      if (result !== 16'h0040 || result_valid !== 1'b1 || start_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    start = 1'b0;
    checks++;
    if (bad != 0) $display("[TB] FAIL hold_stable: got %0d bad cycles expected 0", bad);
    else passes++;
    result_ready = 1'b1;
    #1;
    checks++;
    if (result_valid !== 1'b1) $display("[TB] FAIL hold_valid_at_ready: got %b expected 1", result_valid);
    else passes++;
    @(negedge clk);
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || start_ready !== 1'b1)
      $display("[TB] FAIL hold_release: got valid=%b ready=%b expected valid=0 ready=1", result_valid, start_ready);
    else passes++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tree_clr !== 1'b0)
      $display("[TB] FAIL hold_start_ignored: got busy=%b clr=%b expected 0 0", busy, tree_clr);
    else passes++;
  endtask

  task automatic test_back_to_back();
    fill_const(16'h0001);
    run_vector(4'd0);
    checks++;
    if (result !== 16'h0040) $display("[TB] FAIL b2b_first: got %h expected 0040", result);
    else passes++;
    release_result();
    fill_const(16'h0002);
    run_vector(4'd0);
    checks++;
    if (result !== 16'h0080 || rvCyc !== 23)
      $display("[TB] FAIL b2b_second: got %h at cycle %0d expected 0080 at 23", result, rvCyc);
    else passes++;
    release_result();
  endtask

  task automatic test_midreset();
    int seen;
    fill_const(16'h0001);
    @(negedge clk);
    start     = 1'b1;
    base_addr = 4'd0;
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    checks++;
    if (rd_en !== 1'b1 || rd_addr !== 4'd7)
      $display("[TB] FAIL midreset_beat7: got en=%b addr=%0d expected en=1 addr=7", rd_en, rd_addr);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (tree_clr !== 1'b1) $display("[TB] FAIL midreset_tree_clr: got %b expected 1", tree_clr);
    else passes++;
    @(negedge clk);
    checks++;
    if ({rd_en, rd_addr, stage2_run, stage1_run, stage0_run, result_valid, busy} !== 10'b0 ||
        {inp0, inp1, inp2, inp3, result} !== 80'b0)
      $display("[TB] FAIL midreset_outputs: got ctrl=%b data=%h expected all 0",
               {rd_en, rd_addr, stage2_run, stage1_run, stage0_run, result_valid, busy},
               {inp0, inp1, inp2, inp3, result});
    else passes++;
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (result_valid || stage0_run) seen++;
    end
    checks++;
    if (seen != 0) $display("[TB] FAIL midreset_no_result: got %0d active cycles expected 0", seen);
    else passes++;
    run_vector(4'd0);
    checks++;
    if (result !== 16'h0040 || rvCyc !== 23)
      $display("[TB] FAIL midreset_recover: got %h at cycle %0d expected 0040 at 23", result, rvCyc);
    else passes++;
    release_result();
  endtask

  task automatic test_saturate();
    fill_const(16'h0400);
    run_vector(4'd0);
    checks++;
    if (result !== 16'h7000) $display("[TB] FAIL saturate_result: got %h expected 7000", result);
    else passes++;
    release_result();
  endtask

  initial begin
    $display("[TB] mode4_tree_feeder bench starting");
    test_reset();
    test_basic();
    test_wrap();
    test_hold();
    test_back_to_back();
    test_midreset();
    test_saturate();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
